// File: rtl/uart_rx_frame.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit, sampled mid-bit.
// Delivers the 9-bit frame with a one-cycle valid pulse, a parity flag and a framing-error pulse.
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [8:0] frame,
  output logic       frame_valid,
  output logic       parity_error,
  output logic       framing_error
);

  localparam logic [15:0] HalfM1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FullM1 = 16'(CLKS_PER_BIT - 1);
  localparam logic        Odd    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  logic        brk_q, brk_d;
  logic        rx_meta_q, rx_s;
  logic [8:0]  frame_q, frame_d;
  logic        frame_valid_q, frame_valid_d;
  logic        parity_error_q, parity_error_d;
  logic        framing_error_q, framing_error_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      idx_q           <= '0;
      data_q          <= '0;
      par_q           <= 1'b0;
      brk_q           <= 1'b0;
      frame_q         <= '0;
      frame_valid_q   <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      data_q          <= data_d;
      par_q           <= par_d;
      brk_q           <= brk_d;
      frame_q         <= frame_d;
      frame_valid_q   <= frame_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    data_d          = data_q;
    par_d           = par_q;
    brk_d           = brk_q;
    frame_d         = frame_q;
    frame_valid_d   = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        // After a framing error, wait for the line to return high before re-arming.
        if (brk_q) begin
          if (rx_s) brk_d = 1'b0;
        end else if (!rx_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = StParity;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StParity: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == FullM1) begin
          // Leave mid stop bit so a following start edge is never missed.
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s) begin
            frame_d        = {par_q, data_q};
            frame_valid_d  = 1'b1;
            parity_error_d = (^{par_q, data_q}) ^ Odd;
          end else begin
            framing_error_d = 1'b1;
            brk_d           = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign frame         = frame_q;
  assign frame_valid   = frame_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port frame, output, 9 bits: frame[7:0] is received data, frame[8] is the received parity bit.
REQ-007 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse qualifying frame.
REQ-008 The block SHALL have port parity_error, output, 1 bit: valid only while frame_valid=1; 1 means the parity check failed.
REQ-009 The block SHALL have port framing_error, output, 1 bit: one-cycle pulse when the stop bit is sampled low.

Function
REQ-010 The serial format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-011 rx SHALL pass through a 2-flop synchronizer, reset value 1; all decisions SHALL use the synchronized value rx_s.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, plus a cycle counter (16 bit) and a bit index (3 bit).
REQ-013 IDLE: on rx_s=0, go to START with counter cleared.
REQ-014 START: when counter reaches CLKS_PER_BIT/2-1 (integer division), sample rx_s; if 0, go to DATA with counter cleared and index 0; if 1 (glitch), return to IDLE with no output.
REQ-015 DATA: when counter reaches CLKS_PER_BIT-1, shift rx_s into data bit [index] and clear the counter; after index 7, go to PARITY; otherwise increment index.
REQ-016 PARITY: after CLKS_PER_BIT-1 counts, store rx_s as frame bit 8 and go to STOP.
REQ-017 STOP: after CLKS_PER_BIT-1 counts, sample rx_s and return to IDLE in the same cycle, without waiting for the end of the stop bit.
REQ-018 If the stop sample is 1, on the next cycle frame SHALL update, frame_valid SHALL pulse for exactly one cycle, and parity_error SHALL equal (XOR of the 9 received bits) XOR PARITY_ODD.
REQ-019 If the stop sample is 0, framing_error SHALL pulse for one cycle, frame_valid SHALL stay 0, and frame SHALL keep its previous value.
REQ-020 frame SHALL hold its value between frame_valid pulses.
REQ-021 After a framing error, IDLE SHALL not restart until rx_s has been seen high, so that a held-low line (break) produces exactly one framing_error.
REQ-022 Back-to-back frames with zero idle bits SHALL be received without loss.
REQ-023 rx activity while not in IDLE SHALL not restart the FSM.

Reset
REQ-024 While rst=1: FSM=IDLE, counter=0, index=0, synchronizer flops=1, frame=9'h000, frame_valid=0, parity_error=0, framing_error=0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL resume at the next falling edge of rx_s.

Verification (bench uses CLKS_PER_BIT=16, PARITY_ODD=0)
REQ-026 Send data 0xA5 with parity 0, stop 1 -> frame=9'h0A5, one frame_valid pulse, parity_error=0, about 168 cycles after the start edge.
REQ-027 Send data 0x01 with parity 0 (wrong) -> frame=9'h001, frame_valid pulse, parity_error=1.
REQ-028 Drive a 3-cycle low glitch on rx -> no frame_valid, no framing_error, FSM back in IDLE.
REQ-029 Send data 0x3C with stop bit 0, then hold rx low for 40 bit times -> exactly one framing_error pulse, no frame_valid, frame unchanged.
REQ-030 Send two frames back-to-back, 0x55/p0 then 0xFF/p0, with no idle -> two frame_valid pulses, frame 9'h055 then 9'h0FF.
REQ-031 Assert rst during data bit 4 of a frame, release, then send 0x80/p1 -> no pulse for the aborted frame; frame=9'h180, parity_error=0.
